// File: rtl/basic_gates_pkg.sv
// Shared types and constants for the basic-gate cell self-test sequencer.
// The golden output bytes are built from the RESULT bit positions of the cell.
package basic_gates_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam int IDX_AND    = 0;
  localparam int IDX_OR     = 1;
  localparam int IDX_NAND   = 2;
  localparam int IDX_NOR    = 3;
  localparam int IDX_XOR    = 4;
  localparam int IDX_XNOR   = 5;
  localparam int IDX_A_INV  = 6;
  localparam int IDX_B_BUFF = 7;

  localparam logic [7:0] ONE = 8'h01;

  // Expected cell outputs for {A,B}; these evaluate to 6C, D6, 16 and A3.
  localparam logic [7:0] EXP_00 = (ONE << IDX_NAND) | (ONE << IDX_NOR) |
                                  (ONE << IDX_XNOR) | (ONE << IDX_A_INV);
  localparam logic [7:0] EXP_01 = (ONE << IDX_OR) | (ONE << IDX_NAND) |
                                  (ONE << IDX_XOR) | (ONE << IDX_A_INV) |
                                  (ONE << IDX_B_BUFF);
  localparam logic [7:0] EXP_10 = (ONE << IDX_OR) | (ONE << IDX_NAND) |
                                  (ONE << IDX_XOR);
  localparam logic [7:0] EXP_11 = (ONE << IDX_AND) | (ONE << IDX_OR) |
                                  (ONE << IDX_XNOR) | (ONE << IDX_B_BUFF);

endpackage

// File: rtl/basic_gates_bist_golden.sv
// Golden model of the basic-gate cell: maps the applied {A,B} vector to the
// eight outputs a healthy cell must produce.
module gates_golden
  import basic_gates_pkg::*;
(
  input  logic [1:0] vec,
  output logic [7:0] expected
);

  always_comb begin
    expected = EXP_00;
    case (vec)
      2'b00:   expected = EXP_00;
      2'b01:   expected = EXP_01;
      2'b10:   expected = EXP_10;
      default: expected = EXP_11;
    endcase
  end

endmodule

// File: rtl/basic_gates_bist.sv
// Self-test sequencer for the basic-gate cell: walks {A,B} through all four
// vectors LOOPS times, checks the cell outputs and accumulates failure data.
module basic_gates_bist
  import basic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  output logic       TEST_A,
  output logic       TEST_B,
  input  logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] FAIL_MASK,
  output logic [1:0] FAIL_VEC,
  output logic [3:0] ERR_COUNT
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       do_check;
  logic [1:0] vec;
  logic [3:0] settle_cnt;
  logic [7:0] loop_cnt;
  logic [7:0] expected;
  logic [7:0] mism;

  gates_golden u_golden (
    .vec      (vec),
    .expected (expected)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_next = ST_APPLY;
          accept     = 1'b1;
        end
      end
      ST_APPLY:  state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 4'd0) state_next = ST_CHECK;
      ST_CHECK: begin
        if (vec == 2'd3 && loop_cnt == LAST_LOOP) state_next = ST_FINISH;
        else                                      state_next = ST_APPLY;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (ABORT && state != ST_IDLE) state_next = ST_IDLE;
  end

  // An aborted CHECK must leave the accumulated results untouched.
  assign do_check = (state == ST_CHECK) && !ABORT;
  assign mism     = RESULT ^ expected;

  always_ff @(posedge CLK) begin
    if (accept) begin
      vec      <= 2'd0;
      loop_cnt <= 8'd0;
    end else if (state == ST_APPLY) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end else if (do_check) begin
      vec <= vec + 2'd1;
      if (vec == 2'd3) loop_cnt <= loop_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TEST_A    <= 1'b0;
      TEST_B    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL_MASK <= 8'h00;
      FAIL_VEC  <= 2'b00;
      ERR_COUNT <= 4'd0;
    end else begin
      BUSY <= (state_next != ST_IDLE);
      DONE <= (state_next == ST_FINISH);

      if (state_next == ST_IDLE) begin
        TEST_A <= 1'b0;
        TEST_B <= 1'b0;
      end else if (state == ST_APPLY) begin
        TEST_A <= vec[1];
        TEST_B <= vec[0];
      end

      if (accept) begin
        FAIL_MASK <= 8'h00;
        FAIL_VEC  <= 2'b00;
        ERR_COUNT <= 4'd0;
        PASS      <= 1'b0;
      end

      if (do_check && mism != 8'h00) begin
        FAIL_MASK <= FAIL_MASK | mism;
        if (ERR_COUNT != 4'd15) ERR_COUNT <= ERR_COUNT + 4'd1;
        if (ERR_COUNT == 4'd0)  FAIL_VEC  <= vec;
      end

      // Verdict includes the final check being retired on this same edge.
      if (state_next == ST_FINISH) PASS <= ((FAIL_MASK | mism) == 8'h00);
      if (ABORT && state != ST_IDLE) PASS <= 1'b0;
    end
  end

endmodule

// File: tb/tb_basic_gates_bist.sv
// Bench for basic_gates_bist: three instances with different SETTLE/LOOPS,
// a configurable faulty-cell model each, and a cycle-keyed scoreboard.
module tb_basic_gates_bist;

  localparam int N = 3;
  localparam int SET_P  [N] = '{2, 2, 1};
  localparam int LOOP_P [N] = '{1, 8, 2};

  typedef enum int {F_TEST, F_BUSY, F_DONE, F_PASS, F_MASK, F_FVEC, F_CNT} field_t;
  typedef struct {
    int     inst;
    int     cyc;
    field_t f;
    int     val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n  [N];
  logic       start  [N];
  logic       abort  [N];
  logic       test_a [N];
  logic       test_b [N];
  logic [7:0] result [N];
  logic       busy   [N];
  logic       done   [N];
  logic       pass   [N];
  logic [7:0] mask   [N];
  logic [1:0] fvec   [N];
  logic [3:0] cnt    [N];

  logic [7:0] flip  [N][4];
  logic [7:0] and_m [N];
  logic [7:0] or_m  [N];

  int checks = 0;
  int errors = 0;
  int done_seen [N] = '{0, 0, 0};
  int done_exp  [N] = '{0, 0, 0};

  for (genvar g = 0; g < N; g++) begin : g_dut
    basic_gates_bist #(.SETTLE_CYCLES(SET_P[g]), .LOOPS(LOOP_P[g])) dut (
      .CLK       (clk),
      .RST_N     (rst_n[g]),
      .START     (start[g]),
      .ABORT     (abort[g]),
      .TEST_A    (test_a[g]),
      .TEST_B    (test_b[g]),
      .RESULT    (result[g]),
      .BUSY      (busy[g]),
      .DONE      (done[g]),
      .PASS      (pass[g]),
      .FAIL_MASK (mask[g]),
      .FAIL_VEC  (fvec[g]),
      .ERR_COUNT (cnt[g])
    );
  end

  // Truth table of the gate cell written from the gate functions themselves.
  function automatic logic [7:0] ideal(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  function automatic logic [7:0] cell_of(input int i, input logic [1:0] v);
    return ((ideal(v) ^ flip[i][v]) & and_m[i]) | or_m[i];
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) result[i] = cell_of(i, {test_a[i], test_b[i]});
  end

  function automatic string fname(input field_t f);
    case (f)
      F_TEST:  return "test_ab";
      F_BUSY:  return "busy";
      F_DONE:  return "done";
      F_PASS:  return "pass";
      F_MASK:  return "fail_mask";
      F_FVEC:  return "fail_vec";
      default: return "err_count";
    endcase
  endfunction

  function automatic int actual(input int i, input field_t f);
    case (f)
      F_TEST:  return int'({test_a[i], test_b[i]});
      F_BUSY:  return int'(busy[i]);
      F_DONE:  return int'(done[i]);
      F_PASS:  return int'(pass[i]);
      F_MASK:  return int'(mask[i]);
      F_FVEC:  return int'(fvec[i]);
      default: return int'(cnt[i]);
    endcase
  endfunction

  task automatic check(input string name, input int i, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, i, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_seen[i]++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_%s inst=%0d actual=cyc%0d required=cyc%0d",
                 fname(mon_e.f), mon_e.inst, cyc, mon_e.cyc);
      end else begin
        check(fname(mon_e.f), mon_e.inst, actual(mon_e.inst, mon_e.f), mon_e.val);
      end
    end
  end

  function automatic void push(input int i, input int c, input field_t f, input int v);
    sb.push_back('{inst: i, cyc: c, f: f, val: v});
  endfunction

  function automatic int run_len(input int i);
    return 4 * LOOP_P[i] * (SET_P[i] + 2);
  endfunction

  // tail: 0 = run completes, 1 = abort seen at cycle ta, 2 = reset at cycle ta.
  function automatic void push_run(input int i, input int t0, input int cut,
                                   input int tail, input int ta);
    int s, m, c, fv, td;
    logic [7:0] mm;
    s  = SET_P[i];
    m  = 0;
    c  = 0;
    fv = 0;
    for (int n = 0; n < cut; n++) begin
      mm = cell_of(i, 2'(n % 4)) ^ ideal(2'(n % 4));
      if (mm != 8'h00) begin
        if (c == 0) fv = n % 4;
        m = m | int'(mm);
        c = (c < 15) ? c + 1 : 15;
      end
      push(i, t0 + n * (s + 2) + s + 1, F_TEST, n % 4);
    end
    if (tail == 0) begin
      td = t0 + run_len(i);
      for (int k = 0; k < 2; k++) begin
        push(i, td + k, F_DONE, 1 - k);
        push(i, td + k, F_BUSY, 1 - k);
        push(i, td + k, F_PASS, (m == 0) ? 1 : 0);
        push(i, td + k, F_MASK, m);
        push(i, td + k, F_FVEC, fv);
        push(i, td + k, F_CNT,  c);
      end
      done_exp[i]++;
    end else begin
      push(i, ta, F_BUSY, 0);
      push(i, ta, F_DONE, 0);
      push(i, ta, F_PASS, 0);
      push(i, ta, F_TEST, 0);
      push(i, ta, F_MASK, (tail == 1) ? m  : 0);
      push(i, ta, F_FVEC, (tail == 1) ? fv : 0);
      push(i, ta, F_CNT,  (tail == 1) ? c  : 0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_run(input int i, output int t0);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    t0 = cyc;
  endtask

  task automatic cfg_clear(input int i);
    for (int v = 0; v < 4; v++) flip[i][v] = 8'h00;
    and_m[i] = 8'hFF;
    or_m[i]  = 8'h00;
  endtask

  task automatic cfg_random(input int i);
    for (int v = 0; v < 4; v++)
      flip[i][v] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    and_m[i] = ($urandom_range(0, 3) == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF;
    or_m[i]  = ($urandom_range(0, 3) == 0) ?  (8'h01 << $urandom_range(0, 7)) : 8'h00;
  endtask

  task automatic full_run(input int i);
    int t0;
    start_run(i, t0);
    push_run(i, t0, 4 * LOOP_P[i], 0, 0);
    wait_until(t0 + run_len(i) + 2);
  endtask

  initial begin
    int t0, c, i;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      start[k] = 1'b0;
      abort[k] = 1'b0;
      cfg_clear(k);
    end
    repeat (3) tick();
    c = cyc;
    for (int k = 0; k < N; k++) begin
      push(k, c, F_TEST, 0); push(k, c, F_BUSY, 0); push(k, c, F_DONE, 0);
      push(k, c, F_PASS, 0); push(k, c, F_MASK, 0); push(k, c, F_FVEC, 0);
      push(k, c, F_CNT, 0);
    end
    tick();
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    tick();

    // healthy cell, defaults
    full_run(0);
    // XOR output stuck at 0
    and_m[0] = ~8'h10;
    full_run(0);
    // cell outputs all zero, eight loops
    and_m[1] = 8'h00;
    full_run(1);
    cfg_clear(1);

    // abort during SETTLE of vector 10
    cfg_random(0);
    start_run(0, t0);
    push_run(0, t0, 2, 1, t0 + 2 * (SET_P[0] + 2) + 2);
    wait_until(t0 + 2 * (SET_P[0] + 2) + 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    repeat (3) tick();

    // START re-pulsed while busy
    cfg_clear(0);
    start_run(0, t0);
    push_run(0, t0, 4, 0, 0);
    repeat (5) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_until(t0 + run_len(0) + 2);

    // START and ABORT together in IDLE
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    push(0, cyc, F_BUSY, 0);
    push(0, cyc + 1, F_BUSY, 0);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    repeat (3) tick();

    // reset asserted during CHECK of vector 01, then a clean run
    and_m[0] = 8'h00;
    start_run(0, t0);
    push_run(0, t0, 1, 2, t0 + (SET_P[0] + 2) + SET_P[0] + 1);
    wait_until(t0 + (SET_P[0] + 2) + SET_P[0] + 1);
    rst_n[0] = 1'b0;
    repeat (2) tick();
    rst_n[0] = 1'b1;
    tick();
    cfg_clear(0);
    full_run(0);

    // randomized faulty cells on random instances
    repeat (12) begin
      i = $urandom_range(0, N - 1);
      cfg_random(i);
      repeat ($urandom_range(0, 3)) tick();
      full_run(i);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    check("scoreboard_drained", 0, sb.size(), 0);
    for (int k = 0; k < N; k++) check("done_pulses", k, done_seen[k], done_exp[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_gates_bist.md
# basic_gates_bist

Built-in self-test sequencer for the two-input basic-gate cell (AND/OR/NAND/NOR/XOR/XNOR, A-inverter, B-buffer). On START it drives the cell's A/B inputs through all four input combinations. After a programmable settle time it samples the cell's eight outputs and compares them against a golden model. It then reports pass/fail, an OR-accumulated mismatch mask, the first failing vector and a failing-vector count. The block sits beside the gate cell in the test wrapper and owns the cell's inputs while BUSY.

## Interface
- SETTLE_CYCLES, 2: cycles between applying a vector and sampling RESULT; legal range 1..15.
- LOOPS, 1: number of full passes through the four vectors; legal range 1..255.

- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  reset; asynchronous assert, active-low.
- START  input  1  run request; sampled only in IDLE.
- ABORT  input  1  cancel run; takes effect in any state.
- TEST_A  output  1  drives cell input A.
- TEST_B  output  1  drives cell input B.
- RESULT  input  8  cell outputs: [0]AND [1]OR [2]NAND [3]NOR [4]XOR [5]XNOR [6]A_INV [7]B_BUFF.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse on normal completion.
- PASS  output  1  high from DONE until the next START when no mismatch occurred.
- FAIL_MASK  output  8  OR of (RESULT XOR expected) over all checks of the run.
- FAIL_VEC  output  2  {A,B} of the first failing check of the run.
- ERR_COUNT  output  4  number of failing checks; saturates at 15.

## Operation
- Vector index vec[1:0]; TEST_A = vec[1], TEST_B = vec[0]; order 00, 01, 10, 11.
- Expected RESULT per vec: 00 -> 0x6C, 01 -> 0xD6, 10 -> 0x16, 11 -> 0xA3.
- FSM states: IDLE, APPLY, SETTLE, CHECK, FINISH.
  - IDLE: START=1 and ABORT=0 -> APPLY. On that transition, clear vec, loop counter, FAIL_MASK, FAIL_VEC, ERR_COUNT and PASS.
  - APPLY: register TEST_A/TEST_B from vec and load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to CHECK.
  - CHECK: compute mism = RESULT ^ expected(vec). If mism != 0: FAIL_MASK |= mism; ERR_COUNT increments, saturating at 15; FAIL_VEC is loaded only on the run's first failure. Then vec++.
    - vec wrapping 3->0 on the last loop -> FINISH.
    - vec wrapping 3->0 on an earlier loop -> loop++, APPLY.
    - otherwise -> APPLY.
  - FINISH: DONE=1 for this one cycle; PASS = (FAIL_MASK == 0) including the final CHECK; go to IDLE.
- ABORT=1 in any non-IDLE state -> IDLE next edge. No DONE pulse; PASS=0; TEST_A/TEST_B forced to 0; FAIL_MASK/FAIL_VEC/ERR_COUNT hold their values.
- START while BUSY is ignored. START and ABORT both high in IDLE: stay in IDLE.
- FAIL_MASK/FAIL_VEC/ERR_COUNT/PASS hold after FINISH until the next accepted START.

## Timing
- Reset values: TEST_A=0, TEST_B=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0x00, FAIL_VEC=0, ERR_COUNT=0; state IDLE.
- Reset assertion mid-run returns the block to IDLE immediately (asynchronous) with all outputs at their reset values.
- Each vector takes SETTLE_CYCLES+2 cycles (APPLY, SETTLE x SETTLE_CYCLES, CHECK).
- DONE is high in cycle 4*LOOPS*(SETTLE_CYCLES+2)+1 after the edge that samples START. Defaults give 17.
- RESULT is sampled at the CHECK edge. TEST_A/TEST_B are stable from the edge after APPLY until the next APPLY.
- BUSY rises on the edge that accepts START and falls on the edge leaving FINISH.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package basic_gates_pkg:
  - FSM state enum.
  - RESULT bit-index constants (IDX_AND..IDX_B_BUFF).
  - Expected-vector constants EXP_00/EXP_01/EXP_10/EXP_11.
- Sub-module gates_golden: purely combinational, vec[1:0] -> expected[7:0]; uses the package constants.
- The main module holds the FSM, settle counter, loop counter and result registers.

## Test plan
- Correct cell model, defaults, START pulse -> DONE at cycle 17, PASS=1, FAIL_MASK=0x00, ERR_COUNT=0, TEST_A/B sequence 00,01,10,11.
- RESULT[4] (XOR) stuck-at-0 -> PASS=0, FAIL_MASK=0x10, FAIL_VEC=2'b01, ERR_COUNT=2.
- RESULT forced to 0x00, LOOPS=8 -> 32 failing checks, ERR_COUNT=15 (saturated), FAIL_MASK=0xFF, FAIL_VEC=2'b00, DONE at cycle 129.
- ABORT during the SETTLE of vector 10 -> IDLE next cycle, no DONE, PASS=0, BUSY=0, TEST_A/B=0.
- START re-pulsed while BUSY -> ignored, DONE still at cycle 17. START+ABORT together in IDLE -> BUSY stays 0.
- RST_N low during CHECK -> all outputs at reset values immediately. After release, a new START completes normally with PASS=1.
